// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Word offsets on the bus.
  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  // STATUS register bit positions.
  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Small first-word-fall-through FIFO with push/pop, full/empty and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO still lands when a pop frees the slot in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Next pointer and occupancy values.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; count gates every read, so stale contents are never observed.
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Bus-slave UART transmitter: register decode, TX FIFO and 8N1 serialiser.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        tx_empty_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        enable_q, enable_d;
  logic        ovf_q, ovf_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          last_tick;
  logic          unused_wdata;

  assign unused_wdata = ^wdata_i[31:8];

  assign fifo_push = we_i && (addr_i == ADDR_TXDATA);
  assign last_tick = (baud_q == 16'(CLKS_PER_BIT - 1));

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (wdata_i[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Transmit FSM: next state, baud/bit counters, shifter, and the registered line level.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        if (enable_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = START;
        end
      end
      START: begin
        if (last_tick) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (last_tick) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (last_tick) begin
          baud_d = '0;
          // Chain straight into the next frame when a byte is waiting.
          if (enable_q && !fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level follows the state being entered so tx_o changes on the same edge.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Control and sticky-overflow register updates; overflow set wins over clear.
  always_comb begin
    enable_d = enable_q;
    ovf_d    = ovf_q;
    if (we_i && (addr_i == ADDR_CTRL))                   enable_d = wdata_i[0];
    if (we_i && (addr_i == ADDR_STATUS) && wdata_i[3])   ovf_d    = 1'b0;
    if (fifo_push && fifo_full && !fifo_pop)             ovf_d    = 1'b1;
  end

  // Read mux; reads have no side effects.
  always_comb begin
    rdata_o = '0;
    unique case (addr_i)
      ADDR_STATUS: begin
        rdata_o[ST_BUSY]             = (state_q != IDLE);
        rdata_o[ST_FULL]             = fifo_full;
        rdata_o[ST_EMPTY]            = fifo_empty;
        rdata_o[ST_OVF]              = ovf_q;
        rdata_o[ST_COUNT_LSB +: 4]   = 4'(fifo_count);
      end
      ADDR_CTRL: rdata_o[0] = enable_q;
      default:   rdata_o = '0;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      enable_q  <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      enable_q  <= enable_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx_o       = tx_q;
  assign tx_empty_o = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_uart_tx_mmio;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  localparam logic [1:0] A_TX  = 2'd0;
  localparam logic [1:0] A_ST  = 2'd1;
  localparam logic [1:0] A_CT  = 2'd2;
  localparam logic [1:0] A_RSV = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we_i = 1'b0;
  logic [1:0]  addr_i = 2'd0;
  logic [31:0] wdata_i = 32'd0;
  logic [31:0] rdata_o;
  logic        tx_o;
  logic        tx_empty_o;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .tx_o       (tx_o),
    .tx_empty_o (tx_empty_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus write: strobe is captured on the next rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we_i    = 1'b1;
    addr_i  = a;
    wdata_i = d;
    step();
    we_i    = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr_i = a;
    #1;
    check(tag, rdata_o, exp);
  endtask

  task automatic tx_check(input string tag, input logic exp);
    check(tag, {31'd0, tx_o}, {31'd0, exp});
  endtask

  // Checks one full 8N1 frame, one comparison per clock, starting at the next edge.
  task automatic expect_frame(input string tag, input logic [7:0] b);
    for (int i = 0; i < 10; i++) begin
      logic e;
      if (i == 0)      e = 1'b0;
      else if (i == 9) e = 1'b1;
      else             e = b[i-1];
      for (int c = 0; c < CPB; c++) begin
        step();
        tx_check(tag, e);
      end
    end
  endtask

  initial begin
    // Scenario 1: reset values.
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    tx_check("rst_tx", 1'b1);
    check("rst_empty", {31'd0, tx_empty_o}, 32'd1);
    rd_check("rst_status", A_ST, 32'h0000_0004);
    rd_check("rst_ctrl", A_CT, 32'h0000_0001);
    rd_check("rst_txdata_rd", A_TX, 32'h0);
    wr(A_RSV, 32'hFFFF_FFFF);
    rd_check("rsv_rd", A_RSV, 32'h0);
    rd_check("rsv_wr_ignored_st", A_ST, 32'h0000_0004);
    rd_check("rsv_wr_ignored_ct", A_CT, 32'h0000_0001);

    // Scenario 2: single byte 0x55.
    wr(A_TX, 32'h0000_0055);
    expect_frame("frame_55", 8'h55);
    step();
    rd_check("s2_status", A_ST, 32'h0000_0004);
    check("s2_empty", {31'd0, tx_empty_o}, 32'd1);

    // Scenario 3: six back-to-back pushes, sixth dropped; five contiguous frames.
    wr(A_TX, 32'h41);
    fork
      begin
        wr(A_TX, 32'h42);
        wr(A_TX, 32'h43);
        wr(A_TX, 32'h44);
        wr(A_TX, 32'h45);
        rd_check("s3_peak", A_ST, 32'h0000_0043);
        wr(A_TX, 32'h46);
        rd_check("s3_ovf", A_ST, 32'h0000_004B);
      end
      begin
        expect_frame("frame_41", 8'h41);
        expect_frame("frame_42", 8'h42);
        expect_frame("frame_43", 8'h43);
        expect_frame("frame_44", 8'h44);
        expect_frame("frame_45", 8'h45);
      end
    join
    step();
    rd_check("s3_done", A_ST, 32'h0000_000C);
    check("s3_empty", {31'd0, tx_empty_o}, 32'd1);

    // Scenario 4: overflow clear, and only bit 3 clears it.
    wr(A_ST, 32'h0000_0008);
    rd_check("s4_clr", A_ST, 32'h0000_0004);
    wr(A_CT, 32'h0);
    rd_check("s4_ctrl0", A_CT, 32'h0);
    for (int i = 0; i < 5; i++) wr(A_TX, 32'h60 + 32'(i));
    rd_check("s4_reovf", A_ST, 32'h0000_004A);
    wr(A_ST, 32'hFFFF_FFF7);
    rd_check("s4_keep", A_ST, 32'h0000_004A);
    wr(A_ST, 32'h0000_0008);
    rd_check("s4_clr2", A_ST, 32'h0000_0042);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_check("s4_rst_st", A_ST, 32'h0000_0004);
    rd_check("s4_rst_ct", A_CT, 32'h0000_0001);
    for (int i = 0; i < 6; i++) begin
      step();
      tx_check("s4_quiet", 1'b1);
    end

    // Scenario 5: disable mid-frame, then re-enable.
    wr(A_TX, 32'h12);
    fork
      begin
        wr(A_TX, 32'h34);
        repeat (5) step();
        wr(A_CT, 32'h0);
      end
      expect_frame("frame_12", 8'h12);
    join
    for (int i = 0; i < 8; i++) begin
      step();
      tx_check("s5_hold", 1'b1);
    end
    rd_check("s5_status", A_ST, 32'h0000_0010);
    rd_check("s5_ctrl", A_CT, 32'h0);
    wr(A_CT, 32'h1);
    expect_frame("frame_34", 8'h34);
    step();
    rd_check("s5_done", A_ST, 32'h0000_0004);

    // Scenario 6: reset during DATA with two bytes queued.
    wr(A_TX, 32'hA5);
    wr(A_TX, 32'h3C);
    wr(A_TX, 32'h99);
    repeat (8) step();
    tx_check("s6_bit1", 1'b0);
    rd_check("s6_busy", A_ST, 32'h0000_0021);
    reset = 1'b1;
    step();
    reset = 1'b0;
    tx_check("s6_tx", 1'b1);
    rd_check("s6_status", A_ST, 32'h0000_0004);
    rd_check("s6_ctrl", A_CT, 32'h0000_0001);
    check("s6_empty", {31'd0, tx_empty_o}, 32'd1);
    for (int i = 0; i < 50; i++) begin
      step();
      tx_check("s6_quiet", 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter sitting directly downstream of the RISC_V_Single_Cycle data-memory port: the core's store/load path drives it as a bus slave, and it serialises bytes onto a single 8N1 line. It gives the single-cycle core a console output path in simulation and on hardware. It contains a small TX FIFO so back-to-back stores are absorbed without stalling the core, which has no wait-state support.

## Interface

Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2 and up.
- FIFO_DEPTH, default 4: TX FIFO entries; power of two, 2..8.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- we_i  input  1  bus write strobe, sampled on the rising edge of clk.
- addr_i  input  2  word select: 0 = TXDATA, 1 = STATUS, 2 = CTRL, 3 = reserved.
- wdata_i  input  32  bus write data.
- rdata_o  output  32  bus read data, combinational from addr_i and internal registers.
- tx_o  output  1  serial line; idles high; registered.
- tx_empty_o  output  1  high when the FIFO is empty and the FSM is IDLE; derived from registers.

## Operation

- TXDATA write: push wdata_i[7:0]. Accepted if count < FIFO_DEPTH, or if the FSM pops in the same cycle; count is unchanged on a simultaneous push and pop. Otherwise the byte is dropped and sticky overflow is set. TXDATA reads return 0.
- STATUS read: [0] busy (FSM not IDLE), [1] full, [2] empty, [3] overflow, [7:4] count, remaining bits 0.
- STATUS write: wdata_i[3]=1 clears overflow; all other bits are ignored. Overflow set and clear in the same cycle: set wins.
- CTRL: bit0 enable, read/write, reset value 1. Remaining bits read 0.
- Reserved address: reads return 0, writes are ignored.
- FSM states are IDLE, START, DATA, STOP. A 16-bit-capable baud counter counts 0..CLKS_PER_BIT-1, and a 3-bit bit index tracks the data bit.
  - IDLE: if enable=1 and the FIFO is non-empty, pop into the shift register and go to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx_o = shift[0], LSB first, 8 bits, CLKS_PER_BIT cycles each, then STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. On the last cycle, if enable=1 and the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Clearing enable mid-frame: the current frame completes and no further pop occurs. Queued bytes are retained.
- Reset at any time, including mid-frame: after the edge, tx_o=1, FSM=IDLE, FIFO emptied, overflow=0, enable=1, and counters are 0.

## Timing

- Reset values: tx_o=1, tx_empty_o=1, rdata_o at STATUS = 0x0000_0004, at CTRL = 0x0000_0001.
- A push registers at edge N. The FSM sees the FIFO non-empty and pops at edge N+1, and tx_o goes low after edge N+1.
- One frame lasts exactly 10*CLKS_PER_BIT cycles. Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- busy drops, and tx_empty_o rises, after the last STOP cycle when no byte is queued.
- rdata_o is valid in the same cycle addr_i is presented; there are no read side effects.

## Structure

- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - the register offsets (ADDR_TXDATA=0, ADDR_STATUS=1, ADDR_CTRL=2);
  - the STATUS bit indexes (ST_BUSY, ST_FULL, ST_EMPTY, ST_OVF, ST_COUNT_LSB).
- One sub-module, sync_fifo: parameterised width/depth, push/pop/full/empty/count, with the synchronous active-high reset. The TX FSM, baud counter and register decode stay in uart_tx_mmio.

## Test plan

All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.

1. Reset asserted for 2 cycles, then released -> tx_o=1, tx_empty_o=1, STATUS reads 0x04, CTRL reads 0x01.
2. Write 0x55 to TXDATA at edge N -> tx_o: 0 for cycles N+1..N+4, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles; busy=0 and STATUS=0x04 after 40 cycles.
3. Write 0x41..0x46 on six consecutive edges -> the sixth byte is dropped, STATUS[3]=1, count peaks at 4; serial output is 0x41..0x45 in 200 contiguous cycles with no idle gap.
4. Write 0x08 to STATUS after scenario 3 -> overflow reads 0. Assert set and clear in the same cycle -> overflow reads 1.
5. Queue 0x12 and 0x34, then write CTRL=0 during the first frame's DATA state -> 0x12 completes, tx_o stays 1, count=1. Write CTRL=1 -> START begins on the next edge and 0x34 is sent.
6. Assert reset during the DATA state with 2 bytes queued -> after that edge tx_o=1, STATUS=0x04, CTRL=0x01, and no further frame is sent.
